// File: rtl/addsub_arb_pkg.sv
// Shared types and constants for the two-requester add/sub arbiter.
// Also holds the round-robin winner selection.
package addsub_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic ADD  = 1'b0;
  localparam logic SUB  = 1'b1;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  // Lone valid requester wins; under contention the one not granted last wins.
  function automatic logic pick_winner(input logic [1:0] valid, input logic last_grant);
    logic win;
    win = REQ0;
    case (valid)
      2'b01:   win = REQ0;
      2'b10:   win = REQ1;
      2'b11:   win = ~last_grant;
      default: win = REQ0;
    endcase
    return win;
  endfunction

endpackage

// File: rtl/addsub_core.sv
// Combinational ripple add/subtract: sum = A + (B ^ {W{sub}}) + sub.
// cout is the MSB carry; ovf compares the carries into and out of the MSB.
module addsub_core #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             sub_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             ovf_o
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] b_x;

  always_comb begin
    b_x      = b_i ^ {WIDTH{sub_i}};
    carry    = '0;
    carry[0] = sub_i;
    sum_o    = '0;
    for (int i = 0; i < WIDTH; i++) begin
      sum_o[i]   = a_i[i] ^ b_x[i] ^ carry[i];
      carry[i+1] = (a_i[i] & b_x[i]) | (carry[i] & (a_i[i] ^ b_x[i]));
    end
  end

  assign cout_o = carry[WIDTH];
  assign ovf_o  = carry[WIDTH] ^ carry[WIDTH-1];

endmodule

// File: rtl/addsub_share_arbiter.sv
// Round-robin arbiter plus IDLE/EXEC/RESP sequencer sharing one add/sub core
// between two requesters; results return on a single id-tagged channel.
module addsub_share_arbiter
  import addsub_arb_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_sub,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_sub,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic             rsp_ovf
);

  state_e           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             sub_q, sub_d;
  logic             id_q, id_d;
  logic             rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_sum_q, rsp_sum_d;
  logic             rsp_cout_q, rsp_cout_d;
  logic             rsp_ovf_q, rsp_ovf_d;

  logic             win;
  logic [WIDTH-1:0] core_sum;
  logic             core_cout, core_ovf;

  addsub_core #(.WIDTH(WIDTH)) u_core (
    .a_i    (a_q),
    .b_i    (b_q),
    .sub_i  (sub_q),
    .sum_o  (core_sum),
    .cout_o (core_cout),
    .ovf_o  (core_ovf)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    a_d          = a_q;
    b_d          = b_q;
    sub_d        = sub_q;
    id_d         = id_q;
    rsp_id_d     = rsp_id_q;
    rsp_sum_d    = rsp_sum_q;
    rsp_cout_d   = rsp_cout_q;
    rsp_ovf_d    = rsp_ovf_q;
    req_ready    = 2'b00;
    win          = pick_winner(req_valid, last_grant_q);

    case (state_q)
      IDLE: begin
        // Ready is offered only to the winner and never while reset is held.
        if (rst_n && (req_valid != 2'b00)) begin
          req_ready = (win == REQ1) ? 2'b10 : 2'b01;
          a_d       = (win == REQ1) ? req1_a   : req0_a;
          b_d       = (win == REQ1) ? req1_b   : req0_b;
          sub_d     = (win == REQ1) ? req1_sub : req0_sub;
          id_d      = win;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        rsp_id_d   = id_q;
        rsp_sum_d  = core_sum;
        rsp_cout_d = core_cout;
        rsp_ovf_d  = core_ovf;
        state_d    = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          last_grant_d = rsp_id_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and response registers: cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= REQ1;
      rsp_id_q     <= 1'b0;
      rsp_sum_q    <= '0;
      rsp_cout_q   <= 1'b0;
      rsp_ovf_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      rsp_id_q     <= rsp_id_d;
      rsp_sum_q    <= rsp_sum_d;
      rsp_cout_q   <= rsp_cout_d;
      rsp_ovf_q    <= rsp_ovf_d;
    end
  end

  // Operand capture: only meaningful after a handshake, so no reset needed.
  always_ff @(posedge clk) begin
    a_q   <= a_d;
    b_q   <= b_d;
    sub_q <= sub_d;
    id_q  <= id_d;
  end

  assign rsp_valid = (state_q == RESP);
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_cout  = rsp_cout_q;
  assign rsp_ovf   = rsp_ovf_q;

endmodule
